// File: rtl/avalon_packetizer_if.sv
// Avalon-ST streaming interface: one beat of data with sop/eop framing and an
// empty count of unused low-order bytes on the eop beat.
interface avalon_st_if #(
   parameter int DATA_WIDTH_IN_BYTES = 16
);
   localparam int EMPTY_W = $clog2(DATA_WIDTH_IN_BYTES);

   logic [DATA_WIDTH_IN_BYTES*8-1:0] data;
   logic                             valid;
   logic                             sop;
   logic                             eop;
   logic [EMPTY_W-1:0]               empty;
   logic                             rdy;

   modport master (output data, valid, sop, eop, empty, input rdy);
   modport slave  (input data, valid, sop, eop, empty, output rdy);
endinterface

// File: rtl/avalon_packetizer.sv
// Frames a raw word stream into Avalon-ST messages from a byte-length descriptor,
// through a one-deep registered output stage.
module avalon_packetizer #(
   parameter int DATA_WIDTH_IN_BYTES = 16,
   parameter int LEN_WIDTH           = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [LEN_WIDTH-1:0]             msg_len,
   input  logic                             msg_len_valid,
   output logic                             msg_len_rdy,
   input  logic [DATA_WIDTH_IN_BYTES*8-1:0] raw_data,
   input  logic                             raw_valid,
   output logic                             raw_rdy,
   avalon_st_if.master                      packet_msg,
   output logic                             zero_len_err,
   output logic [15:0]                      msg_sent_cnt
);
   localparam int W       = DATA_WIDTH_IN_BYTES;
   localparam int EMPTY_W = $clog2(W);

   localparam logic [0:0] BETWEEN_MSG = 1'b0;
   localparam logic [0:0] IN_MSG      = 1'b1;

   logic [0:0]           state;
   logic [LEN_WIDTH-1:0] remaining;
   logic                 first;

   logic                 len_hs, raw_hs, out_hs;
   logic                 eop_next;
   logic [EMPTY_W-1:0]   empty_next;
   logic [W*8-1:0]       masked;

   // Gated by rst so the descriptor port reads not-ready while held in reset.
   assign msg_len_rdy = rst && (state == BETWEEN_MSG);
   assign raw_rdy     = (state == IN_MSG) && (!packet_msg.valid || packet_msg.rdy);

   assign len_hs = msg_len_valid && msg_len_rdy;
   assign raw_hs = raw_valid && raw_rdy;
   assign out_hs = packet_msg.valid && packet_msg.rdy;

   assign eop_next   = (remaining <= LEN_WIDTH'(W));
   assign empty_next = eop_next ? EMPTY_W'(LEN_WIDTH'(W) - remaining) : '0;

   // First message byte is the MSB, so the unused tail is the low-order bytes.
   always_comb begin
      masked = raw_data;
      for (int i = 0; i < W; i++)
         if (i < int'(empty_next))
            masked[8*i +: 8] = 8'h00;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state            <= BETWEEN_MSG;
         remaining        <= '0;
         first            <= 1'b0;
         zero_len_err     <= 1'b0;
         msg_sent_cnt     <= '0;
         packet_msg.valid <= 1'b0;
         packet_msg.sop   <= 1'b0;
         packet_msg.eop   <= 1'b0;
         packet_msg.empty <= '0;
         packet_msg.data  <= '0;
      end else begin
         zero_len_err <= 1'b0;

         if (len_hs) begin
            if (msg_len == '0) begin
               zero_len_err <= 1'b1;
            end else begin
               remaining <= msg_len;
               first     <= 1'b1;
               state     <= IN_MSG;
            end
         end

         if (raw_hs) begin
            packet_msg.valid <= 1'b1;
            packet_msg.sop   <= first;
            packet_msg.eop   <= eop_next;
            packet_msg.empty <= empty_next;
            packet_msg.data  <= masked;
            first            <= 1'b0;
            // Clamp at the last beat so remaining never wraps below zero.
            if (eop_next) begin
               remaining <= '0;
               state     <= BETWEEN_MSG;
            end else begin
               remaining <= remaining - LEN_WIDTH'(W);
            end
         end else if (out_hs) begin
            packet_msg.valid <= 1'b0;
         end

         if (out_hs && packet_msg.eop)
            msg_sent_cnt <= msg_sent_cnt + 16'd1;
      end
   end
endmodule

// File: tb/tb_avalon_packetizer.sv
// Directed bench for avalon_packetizer with W = 16: framing, partial last beat,
// zero-length descriptor, backpressure, mid-message reset and back-to-back messages.
module tb_avalon_packetizer;
   localparam int W = 16;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic [15:0]    msg_len = '0;
   logic           msg_len_valid = 1'b0;
   logic           msg_len_rdy;
   logic [W*8-1:0] raw_data = '0;
   logic           raw_valid = 1'b0;
   logic           raw_rdy;
   logic           zero_len_err;
   logic [15:0]    msg_sent_cnt;

   avalon_st_if #(.DATA_WIDTH_IN_BYTES(W)) pm ();

   avalon_packetizer #(.DATA_WIDTH_IN_BYTES(W), .LEN_WIDTH(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .msg_len       (msg_len),
      .msg_len_valid (msg_len_valid),
      .msg_len_rdy   (msg_len_rdy),
      .raw_data      (raw_data),
      .raw_valid     (raw_valid),
      .raw_rdy       (raw_rdy),
      .packet_msg    (pm),
      .zero_len_err  (zero_len_err),
      .msg_sent_cnt  (msg_sent_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W*8-1:0] data;
      logic           sop;
      logic           eop;
      logic [3:0]     empty;
      int             cyc;
   } beat_t;

   beat_t q[$];
   int    cyc_n = 0;
   int    n_chk = 0;
   int    n_err = 0;

   always @(posedge clk) cyc_n++;

   // Handshake will occur on the next posedge; inputs only move just after posedges.
   always @(negedge clk)
      if (rst && pm.valid && pm.rdy)
         q.push_back('{pm.data, pm.sop, pm.eop, pm.empty, cyc_n});

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send_desc(input logic [15:0] len);
      bit ok;
      ok = 1'b0;
      msg_len = len;
      msg_len_valid = 1'b1;
      for (int i = 0; i < 50 && !ok; i++) begin
         #2;
         ok = msg_len_rdy;
         cyc();
      end
      msg_len_valid = 1'b0;
      if (!ok) chk("desc_timeout", 0, 1);
   endtask

   task automatic feed_raw(input logic [W*8-1:0] w);
      bit ok;
      ok = 1'b0;
      raw_data = w;
      raw_valid = 1'b1;
      for (int i = 0; i < 50 && !ok; i++) begin
         #2;
         ok = raw_rdy;
         cyc();
      end
      raw_valid = 1'b0;
      if (!ok) chk("raw_timeout", 0, 1);
   endtask

   task automatic wait_beats(input int n);
      for (int i = 0; i < 60 && q.size() < n; i++) cyc();
      if (q.size() < n) chk("beat_timeout", 128'(q.size()), 128'(n));
   endtask

   localparam logic [127:0] WA = 128'h00112233445566778899AABBCCDDEEFF;
   localparam logic [127:0] WB = 128'h102030405060708090A0B0C0D0E0F000;
   localparam logic [127:0] WC = 128'h0123456789ABCDEFFEDCBA9876543210;
   localparam logic [127:0] WD = 128'hDEADBEEFDEADBEEFDEADBEEFDEADBEEF;
   localparam logic [127:0] WE = 128'hAB112233445566778899AABBCCDDEEFF;

   logic [127:0] held;
   int           cnt0;

   initial begin
      pm.rdy = 1'b1;

      // reset state
      cyc(); cyc();
      chk("rst_valid", 128'(pm.valid), 0);
      chk("rst_data", pm.data, 0);
      chk("rst_len_rdy", 128'(msg_len_rdy), 0);
      chk("rst_raw_rdy", 128'(raw_rdy), 0);
      chk("rst_zerr", 128'(zero_len_err), 0);
      chk("rst_cnt", 128'(msg_sent_cnt), 0);
      rst = 1'b1;
      #1;
      chk("rel_len_rdy", 128'(msg_len_rdy), 1);
      cyc();

      // exact one-beat message
      q.delete();
      send_desc(16);
      feed_raw(WA);
      wait_beats(1);
      cyc(); cyc();
      chk("one_n", 128'(q.size()), 1);
      chk("one_data", q[0].data, WA);
      chk("one_sop", 128'(q[0].sop), 1);
      chk("one_eop", 128'(q[0].eop), 1);
      chk("one_empty", 128'(q[0].empty), 0);
      chk("one_cnt", 128'(msg_sent_cnt), 1);

      // 40 bytes: three beats, last has 8 empty bytes
      q.delete();
      send_desc(40);
      feed_raw(WA);
      feed_raw(WB);
      feed_raw(WC);
      raw_data = WD;
      raw_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #2;
         chk("m40_no4th", 128'(raw_rdy), 0);
         cyc();
      end
      raw_valid = 1'b0;
      wait_beats(3);
      cyc(); cyc();
      chk("m40_n", 128'(q.size()), 3);
      chk("m40_sop", {q[0].sop, q[1].sop, q[2].sop}, 3'b100);
      chk("m40_eop", {q[0].eop, q[1].eop, q[2].eop}, 3'b001);
      chk("m40_d0", q[0].data, WA);
      chk("m40_d1", q[1].data, WB);
      chk("m40_e1", 128'(q[1].empty), 0);
      chk("m40_e2", 128'(q[2].empty), 8);
      chk("m40_d2", q[2].data, 128'h0123456789ABCDEF0000000000000000);
      chk("m40_cnt", 128'(msg_sent_cnt), 2);

      // zero-length descriptor
      q.delete();
      send_desc(0);
      chk("z_err_hi", 128'(zero_len_err), 1);
      chk("z_len_rdy", 128'(msg_len_rdy), 1);
      chk("z_valid", 128'(pm.valid), 0);
      cyc();
      chk("z_err_lo", 128'(zero_len_err), 0);
      chk("z_len_rdy2", 128'(msg_len_rdy), 1);
      send_desc(1);
      feed_raw(WE);
      wait_beats(1);
      cyc();
      chk("l1_n", 128'(q.size()), 1);
      chk("l1_empty", 128'(q[0].empty), 15);
      chk("l1_data", q[0].data, 128'hAB000000000000000000000000000000);
      chk("l1_sopeop", {q[0].sop, q[0].eop}, 2'b11);

      // 64 bytes with a 5-cycle output stall after beat 1
      q.delete();
      send_desc(64);
      fork
         begin
            feed_raw(WA);
            feed_raw(WB);
            feed_raw(WC);
            feed_raw(WD);
         end
         begin
            wait_beats(2);
            pm.rdy = 1'b0;
            #1;
            held = pm.data;
            chk("bp_held", held, WC);
            for (int i = 0; i < 5; i++) begin
               chk("bp_valid", 128'(pm.valid), 1);
               chk("bp_stable", pm.data, held);
               chk("bp_sop", 128'(pm.sop), 0);
               chk("bp_raw_rdy", 128'(raw_rdy), 0);
               cyc();
            end
            pm.rdy = 1'b1;
         end
      join
      wait_beats(4);
      cyc(); cyc();
      chk("bp_n", 128'(q.size()), 4);
      chk("bp_d0", q[0].data, WA);
      chk("bp_d1", q[1].data, WB);
      chk("bp_d2", q[2].data, WC);
      chk("bp_d3", q[3].data, WD);
      chk("bp_flags", {q[0].sop, q[1].sop, q[2].sop, q[3].sop, q[0].eop, q[1].eop, q[2].eop, q[3].eop}, 8'b1000_0001);
      chk("bp_cnt", 128'(msg_sent_cnt), 4);

      // reset after 2 of 4 beats
      q.delete();
      send_desc(64);
      feed_raw(WA);
      feed_raw(WB);
      rst = 1'b0;
      #1;
      chk("mr_valid", 128'(pm.valid), 0);
      chk("mr_flags", {pm.sop, pm.eop, pm.empty}, 0);
      chk("mr_data", pm.data, 0);
      chk("mr_rdys", {msg_len_rdy, raw_rdy}, 0);
      chk("mr_cnt", 128'(msg_sent_cnt), 0);
      cyc(); cyc();
      rst = 1'b1;
      q.delete();
      cyc();
      chk("mr_raw_rdy", 128'(raw_rdy), 0);
      send_desc(17);
      feed_raw(WA);
      feed_raw(WE);
      wait_beats(2);
      cyc(); cyc();
      chk("mr_n", 128'(q.size()), 2);
      chk("mr_b0", {q[0].sop, q[0].eop}, 2'b10);
      chk("mr_b1", {q[1].sop, q[1].eop}, 2'b01);
      chk("mr_e1", 128'(q[1].empty), 15);
      chk("mr_d1", q[1].data, 128'hAB000000000000000000000000000000);
      chk("mr_cnt2", 128'(msg_sent_cnt), 1);

      // back-to-back 16 then 32
      q.delete();
      cnt0 = int'(msg_sent_cnt);
      send_desc(16);
      feed_raw(WA);
      send_desc(32);
      feed_raw(WB);
      feed_raw(WC);
      wait_beats(3);
      cyc(); cyc();
      chk("bb_n", 128'(q.size()), 3);
      chk("bb_gap", 128'(q[1].cyc - q[0].cyc), 2);
      chk("bb_full", 128'(q[2].cyc - q[1].cyc), 1);
      chk("bb_flags", {q[0].sop, q[0].eop, q[1].sop, q[1].eop, q[2].sop, q[2].eop}, 6'b11_10_01);
      chk("bb_cnt", 128'(int'(msg_sent_cnt) - cnt0), 2);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
